// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: round-robin sharing of one pipelined unsigned 16x16
// multiplier core among NUM_REQ requesters of signed operand pairs.
// Operands are converted to magnitudes on issue. An owner/sign tag follows
// each product through the core latency, and the sign-corrected product
// returns to its owner with a one-cycle one-hot strobe.
module mult_share_ctrl #(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   issue_en,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     res_valid,
  output logic [31:0]            res_p,
  output logic                   busy,
  output logic [15:0]            mult_a,
  output logic [15:0]            mult_b,
  input  logic [31:0]            mult_p
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Owner and sign of one issued product, travelling alongside the core.
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] owner;
    logic             neg;
  } tag_t;

  // Two's-complement magnitude; -32768 maps to 0x8000 as an unsigned value.
  function automatic logic [15:0] mag16(input logic [15:0] x);
    return x[15] ? (~x + 16'd1) : x;
  endfunction

  logic [IDX_W-1:0]   r_rr;
  logic [15:0]        r_mult_a;
  logic [15:0]        r_mult_b;
  logic [NUM_REQ-1:0] r_res_valid;
  logic [31:0]        r_res_p;
  // Stage 0 sits beside mult_a/mult_b; stages 1..MULT_LATENCY mirror the core.
  tag_t               r_tag [MULT_LATENCY+1];

  logic               w_found;
  logic [IDX_W-1:0]   w_grant_idx;
  logic [NUM_REQ-1:0] w_grant;
  logic               w_accept;
  logic [15:0]        w_sel_a;
  logic [15:0]        w_sel_b;
  tag_t               w_out_tag;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic               w_busy;

  // Round-robin search starting at r_rr, wrapping modulo NUM_REQ.
  always_comb begin
    int j;
    // NOTE: every variable gets a value before any conditional assignment,
    // so no path leaves it unassigned and no latch is inferred.
    j           = 0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_grant     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(r_rr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!w_found && req_valid[j]) begin
        w_found     = 1'b1;
        w_grant_idx = j[IDX_W-1:0];
      end
    end
    if (w_found) w_grant[w_grant_idx] = 1'b1;
  end

  // Grant is suppressed while held in reset or while issuing is disabled.
  assign req_ready = (RST_N && issue_en) ? w_grant : '0;
  assign w_accept  = |(req_valid & req_ready);
  assign w_sel_a   = req_a[16*w_grant_idx +: 16];
  assign w_sel_b   = req_b[16*w_grant_idx +: 16];

  // Round-robin pointer moves past the requester just served.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr <= '0;
    end else if (w_accept) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (int'(w_grant_idx) == NUM_REQ - 1) r_rr <= '0;
      else                                  r_rr <= w_grant_idx + 1'b1;
    end
  end

  // Issue stage: operand magnitudes to the core plus the matching tag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_mult_a <= '0;
      r_mult_b <= '0;
      r_tag[0] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_accept, owner: w_grant_idx,
                    neg: w_sel_a[15] ^ w_sel_b[15]};
      if (w_accept) begin
        r_mult_a <= mag16(w_sel_a);
        r_mult_b <= mag16(w_sel_b);
      end
    end
  end

  // Tag delay line aligned with the core latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      // NOTE: this small tag array is reset so that products issued before
      // reset can never produce a strobe afterwards.
      for (int i = 1; i <= MULT_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      for (int i = 1; i <= MULT_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_out_tag = r_tag[MULT_LATENCY];

  // One-hot owner decode of the tag leaving the delay line.
  always_comb begin
    w_owner_oh = '0;
    w_owner_oh[w_out_tag.owner] = 1'b1;
  end

  // Result stage: sign correction and one-cycle strobe to the owner.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res_valid <= '0;
      r_res_p     <= '0;
    end else if (w_out_tag.valid) begin
      r_res_valid <= w_owner_oh;
      r_res_p     <= w_out_tag.neg ? (~mult_p + 32'd1) : mult_p;
    end else begin
      r_res_valid <= '0;
    end
  end

  // Busy from registered state only: any tag in flight or a strobe now.
  always_comb begin
    w_busy = |r_res_valid;
    for (int i = 0; i <= MULT_LATENCY; i++) w_busy = w_busy | r_tag[i].valid;
  end

  assign mult_a    = r_mult_a;
  assign mult_b    = r_mult_b;
  assign res_valid = r_res_valid;
  assign res_p     = r_res_p;
  assign busy      = w_busy;

endmodule
